// File: rtl/lapido_dmem_responder.sv
// Timed, back-pressurable data-memory responder for the MEM stage (INIT/IDLE/WAIT/RESP).
// Define LAPIDO_DMEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH instead of wrapping them.
module lapido_dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic                    oob_q;
  logic                    req_oob;
  logic                    accept, commit, done;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef LAPIDO_DMEM_BOUNDS_CHECK_EN
  assign req_oob = (req_addr >= ADDR_WIDTH'(DEPTH));
`else
  // Upper address bits are dropped, so accesses wrap modulo DEPTH.
  logic unused_addr;
  assign req_oob     = 1'b0;
  assign unused_addr = &{1'b0, req_addr[ADDR_WIDTH-1:IDX_W]};
`endif

  assign accept = (state == S_IDLE) && req_valid;
  assign commit = (state == S_WAIT) && (cnt == '0);
  assign done   = (state == S_RESP) && resp_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through this block infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_INIT: next_state = S_IDLE;
      S_IDLE: if (req_valid)  next_state = S_WAIT;
      S_WAIT: if (cnt == '0)  next_state = S_RESP;
      S_RESP: if (resp_ready) next_state = S_IDLE;
      default: next_state = S_INIT;
    endcase
  end

  // LATENCY==1 loads a zero count, so WAIT commits on the very next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      oob_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_W'(LATENCY - 1);
      idx_q   <= req_addr[IDX_W-1:0];
      wdata_q <= req_wdata;
      write_q <= req_write;
      oob_q   <= req_oob;
    end else if (state == S_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (state == S_INIT) req_ready <= 1'b1;
      if (accept) begin
        req_ready <= 1'b0;
        busy      <= 1'b1;
      end
      if (commit) begin
        resp_valid <= 1'b1;
        resp_rdata <= (write_q || oob_q) ? '0 : mem[idx_q];
        resp_err   <= oob_q;
      end
      if (done) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
        busy       <= 1'b0;
        req_ready  <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit && write_q && !oob_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_lapido_dmem_responder.sv
// Scoreboard bench for lapido_dmem_responder: random loads/stores vs. an array model,
// plus directed reset, backpressure, bounds and LATENCY=1 timing checks.
module tb_lapido_dmem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  logic          clk, rst;
  logic          req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, resp_rdata;

  logic          req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1, busy1;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata1, resp_rdata1;

  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_bad = 0;
  bit            auto_ready;

  lapido_dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  lapido_dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random response backpressure while auto_ready is set.
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_ready) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: every cycle a response is shown it must match the oldest expectation.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", resp_valid, 1'b0);
        end else begin
          e = sb[0];
          if (!prev_v) check("resp_latency", cyc - e.acc, LAT);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
          check("req_ready_in_resp", req_ready, 1'b0);
          check("busy_in_resp", busy, 1'b1);
          if (resp_ready) void'(sb.pop_front());
        end
      end
      prev_v = resp_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", req_ready, 1'b1);
  endtask

  // Issue one request; the reference model applies it at issue time since
  // transactions complete strictly in order, one at a time.
  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    exp_t e;
    int   idx;
    bit   oob;
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    idx = int'(addr % DEPTH);
    oob = 1'b0;
`ifdef LAPIDO_DMEM_BOUNDS_CHECK_EN
    oob = (addr >= DEPTH);
`endif
    if (wr) begin
      if (!oob) model[idx] = wdata;
      e.rdata = '0;
    end else begin
      e.rdata = oob ? '0 : model[idx];
    end
    e.err = oob;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b0);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_rdata"}, resp_rdata, '0);
    check({tag, "_resp_err"}, resp_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // LATENCY=1 instance: accept at edge t, resp_valid after t+1, req_ready back after t+2.
  task automatic lat1_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
    @(negedge clk);
    check("l1_ready_before", req_ready1, 1'b1);
    resp_ready1 = 1'b1;
    req_valid1  = 1'b1;
    req_write1  = wr;
    req_addr1   = addr;
    req_wdata1  = wdata;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    check("l1_accept_valid", resp_valid1, 1'b0);
    check("l1_accept_ready", req_ready1, 1'b0);
    @(posedge clk);
    #1;
    check("l1_resp_valid", resp_valid1, 1'b1);
    check("l1_resp_rdata", resp_rdata1, exp_rdata);
    check("l1_resp_err", resp_err1, 1'b0);
    @(posedge clk);
    #1;
    check("l1_done_valid", resp_valid1, 1'b0);
    check("l1_done_ready", req_ready1, 1'b1);
    check("l1_done_busy", busy1, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0;
    resp_ready = 1'b0; resp_ready1 = 1'b0;
    auto_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);
    check("init_req_ready", req_ready, 1'b1);
    check("init_busy", busy, 1'b0);

    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), $urandom);

    do_req(1'b1, 32'd5, 32'hDEADBEEF);
    do_req(1'b0, 32'd5, 32'h0);
    drain();

    // Held response under backpressure; requests to addr 9 meanwhile must vanish.
    @(posedge clk);
    #1;
    auto_ready = 1'b0;
    resp_ready = 1'b0;
    do_req(1'b0, 32'd5, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", resp_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'd9;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    auto_ready = 1'b1;
    drain();
    repeat (6) @(negedge clk);

    // Reset while a store sits in WAIT: the store must not land.
    do_req(1'b1, 32'd7, 32'h11111111);
    drain();
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd7;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rerelease_req_ready", req_ready, 1'b1);
    do_req(1'b0, 32'd7, 32'h0);
    drain();

    // Out-of-range address: flagged with the bounds macro, wrapped without it.
    do_req(1'b1, 32'd0, 32'hCAFE0000);
    do_req(1'b0, 32'd1024, 32'h0);
    do_req(1'b1, 32'd1024, 32'h00001234);
    do_req(1'b0, 32'd0, 32'h0);
    drain();

    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a + AW'(DEPTH * $urandom_range(1, 3));
      do_req(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    lat1_txn(1'b1, 32'd3, 32'h0BADF00D, 32'h0);
    lat1_txn(1'b0, 32'd3, 32'h0, 32'h0BADF00D);

    repeat (5) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
